// File: rtl/draw_if.sv
// Operand/result bundle for the draw transform pipeline.
// The master drives the request side and the slave returns screen coordinates.
interface draw_if;
    logic               start;
    logic signed [15:0] model_matrix      [16];
    logic signed [15:0] view_matrix       [16];
    logic signed [15:0] projection_matrix [16];
    logic signed [15:0] vertex_a [4];
    logic signed [15:0] vertex_b [4];
    logic signed [15:0] vertex_c [4];
    logic signed [15:0] width;
    logic signed [15:0] height;
    logic signed [15:0] V1 [2];
    logic signed [15:0] V2 [2];
    logic signed [15:0] V3 [2];
    logic               busy;
    logic               done;

    modport master (
        output start, model_matrix, view_matrix, projection_matrix,
               vertex_a, vertex_b, vertex_c, width, height,
        input  V1, V2, V3, busy, done
    );

    modport slave (
        input  start, model_matrix, view_matrix, projection_matrix,
               vertex_a, vertex_b, vertex_c, width, height,
        output V1, V2, V3, busy, done
    );
endinterface

// File: rtl/draw.sv
// Fixed-point MVP transform of three vertices to screen space.
// Latch, then view*model, projection*VM, clip, perspective divide, viewport map.
module draw #(
    parameter int FRAC = 8
) (
    input  logic   Clk,
    input  logic   Reset,
    draw_if.slave  bus
);

    typedef enum logic [2:0] {ST_IDLE, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5} state_t;
    typedef logic signed [15:0] mat_t [16];

    localparam logic signed [15:0] ONE = 16'(1 << FRAC);

    function automatic logic signed [15:0] dot4(
        input logic signed [15:0] a0, a1, a2, a3,
        input logic signed [15:0] b0, b1, b2, b3
    );
        logic signed [31:0] p0, p1, p2, p3;
        logic signed [33:0] acc;
        p0  = 32'(a0) * 32'(b0);
        p1  = 32'(a1) * 32'(b1);
        p2  = 32'(a2) * 32'(b2);
        p3  = 32'(a3) * 32'(b3);
        acc = 34'(p0) + 34'(p1) + 34'(p2) + 34'(p3);
        acc = acc >>> FRAC;
        return acc[15:0];
    endfunction

    function automatic logic signed [15:0] fx_mul(input logic signed [15:0] a, b);
        logic signed [31:0] p;
        p = 32'(a) * 32'(b);
        p = p >>> FRAC;
        return p[15:0];
    endfunction

    // A zero w collapses the vertex onto the viewport centre instead of faulting.
    function automatic logic signed [15:0] fx_div(input logic signed [15:0] num, den);
        logic signed [31:0] n, d, q;
        if (den == 16'sd0) return 16'sd0;
        n = 32'(num) <<< FRAC;
        d = 32'(den);
        q = n / d;
        return q[15:0];
    endfunction

    function automatic logic signed [15:0] to_screen(input logic signed [15:0] ndc, size);
        logic signed [15:0] t;
        t = fx_mul(ndc + ONE, size);
        return t >>> 1;
    endfunction

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    mat_t               model_q, model_d, view_q, view_d, proj_q, proj_d;
    mat_t               vm_q, vm_d, mvp_q, mvp_d;
    logic signed [15:0] vert_q [3][4];
    logic signed [15:0] vert_d [3][4];
    logic signed [15:0] clip_q [3][4];
    logic signed [15:0] clip_d [3][4];
    logic signed [15:0] ndc_q  [3][2];
    logic signed [15:0] ndc_d  [3][2];
    logic signed [15:0] out_q  [3][2];
    logic signed [15:0] out_d  [3][2];
    logic signed [15:0] width_q, width_d, height_q, height_d;

    always_comb begin
        state_d  = state_q;
        model_d  = model_q;
        view_d   = view_q;
        proj_d   = proj_q;
        vm_d     = vm_q;
        mvp_d    = mvp_q;
        vert_d   = vert_q;
        clip_d   = clip_q;
        ndc_d    = ndc_q;
        out_d    = out_q;
        width_d  = width_q;
        height_d = height_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    for (int i = 0; i < 16; i++) begin
                        model_d[i] = bus.model_matrix[i];
                        view_d[i]  = bus.view_matrix[i];
                        proj_d[i]  = bus.projection_matrix[i];
                    end
                    for (int k = 0; k < 4; k++) begin
                        vert_d[0][k] = bus.vertex_a[k];
                        vert_d[1][k] = bus.vertex_b[k];
                        vert_d[2][k] = bus.vertex_c[k];
                    end
                    width_d  = bus.width;
                    height_d = bus.height;
                    state_d  = ST_S1;
                end
            end
            ST_S1: begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        vm_d[r*4+c] = dot4(view_q[r*4], view_q[r*4+1], view_q[r*4+2], view_q[r*4+3],
                                           model_q[c], model_q[4+c], model_q[8+c], model_q[12+c]);
                state_d = ST_S2;
            end
            ST_S2: begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        mvp_d[r*4+c] = dot4(proj_q[r*4], proj_q[r*4+1], proj_q[r*4+2], proj_q[r*4+3],
                                            vm_q[c], vm_q[4+c], vm_q[8+c], vm_q[12+c]);
                state_d = ST_S3;
            end
            ST_S3: begin
                for (int v = 0; v < 3; v++)
                    for (int r = 0; r < 4; r++)
                        clip_d[v][r] = dot4(mvp_q[r*4], mvp_q[r*4+1], mvp_q[r*4+2], mvp_q[r*4+3],
                                            vert_q[v][0], vert_q[v][1], vert_q[v][2], vert_q[v][3]);
                state_d = ST_S4;
            end
            ST_S4: begin
                for (int v = 0; v < 3; v++) begin
                    ndc_d[v][0] = fx_div(clip_q[v][0], clip_q[v][3]);
                    ndc_d[v][1] = fx_div(clip_q[v][1], clip_q[v][3]);
                end
                state_d = ST_S5;
            end
            ST_S5: begin
                for (int v = 0; v < 3; v++) begin
                    out_d[v][0] = to_screen(ndc_q[v][0], width_q);
                    out_d[v][1] = to_screen(ndc_q[v][1], height_q);
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_S5);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            model_q  <= '{default: '0};
            view_q   <= '{default: '0};
            proj_q   <= '{default: '0};
            vm_q     <= '{default: '0};
            mvp_q    <= '{default: '0};
            vert_q   <= '{default: '0};
            clip_q   <= '{default: '0};
            ndc_q    <= '{default: '0};
            out_q    <= '{default: '0};
            width_q  <= '0;
            height_q <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            model_q  <= model_d;
            view_q   <= view_d;
            proj_q   <= proj_d;
            vm_q     <= vm_d;
            mvp_q    <= mvp_d;
            vert_q   <= vert_d;
            clip_q   <= clip_d;
            ndc_q    <= ndc_d;
            out_q    <= out_d;
            width_q  <= width_d;
            height_q <= height_d;
        end
    end

    assign bus.V1[0] = out_q[0][0];
    assign bus.V1[1] = out_q[0][1];
    assign bus.V2[0] = out_q[1][0];
    assign bus.V2[1] = out_q[1][1];
    assign bus.V3[0] = out_q[2][0];
    assign bus.V3[1] = out_q[2][1];
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_draw.sv
// Directed bench for draw: hand-computed Q8.8 screen coordinates, latency,
// busy-time start rejection and reset abort.
module tb_draw;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    draw_if bus();

    draw #(.FRAC(8)) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string tag,
                                input logic [15:0] e1x, e1y, e2x, e2y, e3x, e3y);
        check({tag, ".V1x"}, bus.V1[0], e1x);
        check({tag, ".V1y"}, bus.V1[1], e1y);
        check({tag, ".V2x"}, bus.V2[0], e2x);
        check({tag, ".V2y"}, bus.V2[1], e2y);
        check({tag, ".V3x"}, bus.V3[0], e3x);
        check({tag, ".V3y"}, bus.V3[1], e3y);
    endtask

    task automatic set_identity();
        for (int i = 0; i < 16; i++) begin
            bus.model_matrix[i]      = (i % 5 == 0) ? 16'h0100 : 16'h0000;
            bus.view_matrix[i]       = (i % 5 == 0) ? 16'h0100 : 16'h0000;
            bus.projection_matrix[i] = (i % 5 == 0) ? 16'h0100 : 16'h0000;
        end
    endtask

    task automatic set_vertex(input int which, input logic [15:0] x, y, z, w);
        case (which)
            0: begin bus.vertex_a[0] = x; bus.vertex_a[1] = y; bus.vertex_a[2] = z; bus.vertex_a[3] = w; end
            1: begin bus.vertex_b[0] = x; bus.vertex_b[1] = y; bus.vertex_b[2] = z; bus.vertex_b[3] = w; end
            default: begin bus.vertex_c[0] = x; bus.vertex_c[1] = y; bus.vertex_c[2] = z; bus.vertex_c[3] = w; end
        endcase
    endtask

    // Pulse start for one cycle and count cycles until done (bounded).
    task automatic apply_stimulus(input string tag);
        int lat;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, ".latency"}, 16'(lat), 16'd6);
        check({tag, ".busy_at_done"}, {15'b0, bus.busy}, 16'd0);
    endtask

    initial begin
        int n_done;
        int done_cyc;

        reset     = 1'b1;
        bus.start = 1'b1;
        set_identity();
        bus.width  = 16'h1E00;
        bus.height = 16'h2800;
        set_vertex(0, 16'h0000, 16'h0000, 16'h0000, 16'h0100);
        set_vertex(1, 16'h0100, 16'h0100, 16'h0000, 16'h0100);
        set_vertex(2, 16'hFF00, 16'hFF00, 16'h0000, 16'h0100);
        tick();
        tick();
        reset     = 1'b0;
        bus.start = 1'b0;
        check("reset.busy", {15'b0, bus.busy}, 16'd0);
        check("reset.done", {15'b0, bus.done}, 16'd0);
        check_output("reset", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        tick();
        check("reset_priority.busy", {15'b0, bus.busy}, 16'd0);

        $display("[TB] identity centre/corners");
        apply_stimulus("t1");
        check_output("t1", 16'h0F00, 16'h1400, 16'h1E00, 16'h2800, 16'h0000, 16'h0000);

        $display("[TB] back-to-back start: w scaling, w=0, truncating divide");
        set_vertex(0, 16'h0200, 16'h0000, 16'h0000, 16'h0200);
        set_vertex(1, 16'h0100, 16'h0100, 16'h0000, 16'h0000);
        set_vertex(2, 16'hFF00, 16'h0100, 16'h0000, 16'h0300);
        apply_stimulus("t2");
        check_output("t2", 16'h1E00, 16'h1400, 16'h0F00, 16'h1400, 16'h0A05, 16'h1AA4);
        tick();
        check("t2.done_one_cycle", {15'b0, bus.done}, 16'd0);
        check("t2.hold_V3x", bus.V3[0], 16'h0A05);

        $display("[TB] model translation");
        set_identity();
        bus.model_matrix[3] = 16'h0100;
        set_vertex(0, 16'hFF00, 16'h0000, 16'h0000, 16'h0100);
        set_vertex(1, 16'h0000, 16'h0000, 16'h0000, 16'h0100);
        set_vertex(2, 16'h0100, 16'h0000, 16'h0000, 16'h0100);
        apply_stimulus("t3");
        check_output("t3", 16'h0F00, 16'h1400, 16'h1E00, 16'h1400, 16'h2D00, 16'h1400);

        $display("[TB] chained view/model/projection");
        set_identity();
        bus.view_matrix[7]  = 16'h0100;
        bus.model_matrix[0] = 16'h0200;
        bus.model_matrix[5] = 16'h0200;
        bus.model_matrix[10] = 16'h0200;
        bus.projection_matrix[0] = 16'h0080;
        set_vertex(0, 16'h0100, 16'h0080, 16'h0000, 16'h0100);
        set_vertex(1, 16'h0000, 16'h0000, 16'h0000, 16'h0100);
        set_vertex(2, 16'h0100, 16'h0100, 16'h0000, 16'h0000);
        apply_stimulus("t4");
        check_output("t4", 16'h1E00, 16'h3C00, 16'h0F00, 16'h2800, 16'h0F00, 16'h1400);

        $display("[TB] start ignored while busy");
        set_identity();
        set_vertex(0, 16'h0100, 16'h0100, 16'h0000, 16'h0100);
        set_vertex(1, 16'h0000, 16'h0000, 16'h0000, 16'h0100);
        set_vertex(2, 16'hFF00, 16'hFF00, 16'h0000, 16'h0100);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_done   = 0;
        done_cyc = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (bus.done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (cyc == 3) check("t5.hold_during_busy", bus.V1[1], 16'h3C00);
            if (cyc == 2) begin
                set_vertex(0, 16'h0000, 16'h0000, 16'h0000, 16'h0100);
                set_vertex(2, 16'h0100, 16'h0100, 16'h0000, 16'h0100);
            end
            bus.start = (cyc == 2 || cyc == 4);
            tick();
        end
        bus.start = 1'b0;
        check("t5.done_count", 16'(n_done), 16'd1);
        check("t5.done_cycle", 16'(done_cyc), 16'd6);
        check_output("t5", 16'h1E00, 16'h2800, 16'h0F00, 16'h1400, 16'h0000, 16'h0000);

        $display("[TB] reset abort in cycle 3");
        set_vertex(0, 16'h0100, 16'h0100, 16'h0000, 16'h0100);
        set_vertex(1, 16'h0100, 16'h0100, 16'h0000, 16'h0100);
        set_vertex(2, 16'h0100, 16'h0100, 16'h0000, 16'h0100);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6.busy_after_reset", {15'b0, bus.busy}, 16'd0);
        check("t6.done_after_reset", {15'b0, bus.done}, 16'd0);
        check_output("t6.cleared", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        n_done = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (bus.done) n_done++;
            tick();
        end
        check("t6.no_done_after_abort", 16'(n_done), 16'd0);
        check("t6.V1x_still_zero", bus.V1[0], 16'h0000);

        set_vertex(0, 16'h0000, 16'h0000, 16'h0000, 16'h0100);
        set_vertex(1, 16'h0100, 16'h0100, 16'h0000, 16'h0100);
        set_vertex(2, 16'hFF00, 16'hFF00, 16'h0000, 16'h0100);
        apply_stimulus("t7");
        check_output("t7", 16'h0F00, 16'h1400, 16'h1E00, 16'h2800, 16'h0000, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
